// File: rtl/p_mul_mc.sv
// p_mul_mc: multi-cycle packed-SIMD multiplier.
// The lane width is runtime-selectable. Each lane produces either the low
// or the high half of an unsigned integer product, or of a carry-less
// product. The multiplier is retired BPC bits per cycle.
//
// Datapath idea: every operand lane is zero-extended into a 2W-bit lane of
// a 2*XLEN-bit multiplicand vector. Each multiplier bit t adds (or XORs)
// a_i << t into the lane's 2W-bit accumulator.
//   - Bits with t >= W are masked off, so the multiplicand can be shifted
//     as one flat vector without leaking into the neighbouring lane.
//   - Partial sums of a W x W product always fit in 2W bits, so a flat
//     wide adder never carries across a lane boundary.
module p_mul_mc #(
    parameter int XLEN = 32,
    parameter int BPC  = 4,
    localparam int PWW = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            valid,
    output logic            ready,
    input  logic            mul_l,
    input  logic            mul_h,
    input  logic            clmul,
    input  logic [PWW-1:0]  pw,
    input  logic [XLEN-1:0] crs1,
    input  logic [XLEN-1:0] crs2,
    output logic [XLEN-1:0] result
);

    localparam int NCYC = XLEN / BPC;
    localparam int CW   = $clog2(NCYC + 1);
    localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state_r;
    logic [CW-1:0]      cnt_r;
    logic [2*XLEN-1:0]  acc_r;
    logic [2*XLEN-1:0]  m_r;
    logic [XLEN-1:0]    b_r;
    logic [PWW-1:0]     pw_r;
    logic               mul_l_r;
    logic               mul_h_r;
    logic               clmul_r;
    logic               ready_r;
    logic [XLEN-1:0]    result_r;

    logic [2*XLEN-1:0]  acc_s;
    logic [2*XLEN-1:0]  en_s;
    logic [2*XLEN-1:0]  addend_s;
    logic [XLEN+BPC-1:0] bx_s;
    logic [XLEN-1:0]    res_s;
    logic [PWW-1:0]     pwn_s;

    // Keep only the lowest set bit of pw; an all-zero pw selects full width.
    function automatic logic [PWW-1:0] norm_pw(input logic [PWW-1:0] p);
        logic [PWW-1:0] low;
        low = p & (~p + {{(PWW-1){1'b0}}, 1'b1});
        return (low == {PWW{1'b0}}) ? {{(PWW-1){1'b0}}, 1'b1} : low;
    endfunction

    // Zero-extend each W-bit lane of a into a 2W-bit lane (pwn is one-hot).
    function automatic logic [2*XLEN-1:0] spread(input logic [XLEN-1:0] a,
                                                 input logic [PWW-1:0]  pwn);
        logic [2*XLEN-1:0] v;
        int w;
        int lane;
        int q;
        v = {(2*XLEN){1'b0}};
        for (int s = 0; s < PWW; s++) begin
            for (int p = 0; p < 2*XLEN; p++) begin
                w    = XLEN >> s;
                lane = p / (2*w);
                q    = p % (2*w);
                v[p] = v[p] | (pwn[s] & (q < w) & a[lane*w + (q % w)]);
            end
        end
        return v;
    endfunction

    // Pick the low or high W bits out of every 2W-bit product lane.
    function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] acc,
                                                input logic [PWW-1:0]    pwn,
                                                input logic              hi);
        logic [XLEN-1:0] v;
        int w;
        int lane;
        int q;
        v = {XLEN{1'b0}};
        for (int s = 0; s < PWW; s++) begin
            for (int p = 0; p < XLEN; p++) begin
                w    = XLEN >> s;
                lane = p / w;
                q    = p % w;
                v[p] = v[p] | (pwn[s] & acc[lane*2*w + (hi ? w : 0) + q]);
            end
        end
        return v;
    endfunction

    assign pwn_s = norm_pw(pw);
    assign bx_s  = {{BPC{1'b0}}, b_r};

    // One RUN step: fold the next BPC multiplier bits of every lane into the accumulator.
    always_comb begin
        acc_s    = acc_r;
        en_s     = {(2*XLEN){1'b0}};
        addend_s = {(2*XLEN){1'b0}};
        for (int k = 0; k < BPC; k++) begin
            en_s = {(2*XLEN){1'b0}};
            for (int s = 0; s < PWW; s++) begin
                for (int p = 0; p < 2*XLEN; p++) begin
                    en_s[p] = en_s[p] |
                              (pw_r[s] &
                               ((int'(cnt_r) * BPC + k) < (XLEN >> s)) &
                               bx_s[(p / (2*(XLEN >> s))) * (XLEN >> s) + k]);
                end
            end
            addend_s = (m_r << k) & en_s;
            if (clmul_r) begin
                acc_s = acc_s ^ addend_s;
            end else begin
                acc_s = acc_s + addend_s;
            end
        end
    end

    // Select the requested product half from the completed accumulator.
    always_comb begin
        if (mul_h_r) begin
            res_s = extract(acc_s, pw_r, 1'b1);
        end else if (mul_l_r || clmul_r) begin
            res_s = extract(acc_s, pw_r, 1'b0);
        end else begin
            res_s = {XLEN{1'b0}};
        end
    end

    // Control FSM, operand capture, accumulation and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {(2*XLEN){1'b0}};
            m_r      <= {(2*XLEN){1'b0}};
            b_r      <= {XLEN{1'b0}};
            pw_r     <= {{(PWW-1){1'b0}}, 1'b1};
            mul_l_r  <= 1'b0;
            mul_h_r  <= 1'b0;
            clmul_r  <= 1'b0;
            ready_r  <= 1'b0;
            result_r <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r  <= 1'b0;
                    result_r <= {XLEN{1'b0}};
                    if (valid) begin
                        cnt_r   <= {CW{1'b0}};
                        acc_r   <= {(2*XLEN){1'b0}};
                        m_r     <= spread(crs1, pwn_s);
                        b_r     <= crs2;
                        pw_r    <= pwn_s;
                        mul_l_r <= mul_l;
                        mul_h_r <= mul_h;
                        clmul_r <= clmul;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (!valid) begin
                        state_r  <= IDLE;
                        ready_r  <= 1'b0;
                        result_r <= {XLEN{1'b0}};
                    end else begin
                        acc_r <= acc_s;
                        m_r   <= m_r << BPC;
                        b_r   <= b_r >> BPC;
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        if (cnt_r == LAST) begin
                            state_r  <= DONE;
                            ready_r  <= 1'b1;
                            result_r <= res_s;
                        end else begin
                            state_r  <= RUN;
                            ready_r  <= 1'b0;
                            result_r <= {XLEN{1'b0}};
                        end
                    end
                end
                DONE: begin
                    state_r  <= IDLE;
                    ready_r  <= 1'b0;
                    result_r <= {XLEN{1'b0}};
                end
                default: begin
                    state_r  <= IDLE;
                    ready_r  <= 1'b0;
                    result_r <= {XLEN{1'b0}};
                end
            endcase
        end
    end

    assign ready  = ready_r;
    assign result = result_r;

endmodule

// File: tb/tb_p_mul_mc.sv
// tb_p_mul_mc: table-driven and randomized checks of p_mul_mc (XLEN=32, BPC=4)
// against a lane-by-lane arithmetic reference model.
module tb_p_mul_mc;

    localparam int XLEN = 32;
    localparam int BPC  = 4;
    localparam int PWW  = 5;
    localparam int LAT  = XLEN / BPC + 1;

    logic            clock = 1'b0;
    logic            reset;
    logic            valid;
    logic            ready;
    logic            mul_l;
    logic            mul_h;
    logic            clmul;
    logic [PWW-1:0]  pw;
    logic [XLEN-1:0] crs1;
    logic [XLEN-1:0] crs2;
    logic [XLEN-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    p_mul_mc #(.XLEN(XLEN), .BPC(BPC)) dut (
        .clock  (clock),
        .reset  (reset),
        .valid  (valid),
        .ready  (ready),
        .mul_l  (mul_l),
        .mul_h  (mul_h),
        .clmul  (clmul),
        .pw     (pw),
        .crs1   (crs1),
        .crs2   (crs2),
        .result (result)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  p;
        logic        l;
        logic        h;
        logic        c;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: split into lanes, multiply with plain arithmetic, pick the half.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] p, input logic l,
                                          input logic h, input logic c);
        int s;
        int w;
        longint unsigned mask, ai, bi, prod, lane;
        logic [31:0] r;
        s = 0;
        for (int i = PWW - 1; i >= 0; i--) begin
            if (p[i]) s = i;
        end
        w    = XLEN >> s;
        mask = (64'd1 << w) - 64'd1;
        r    = 32'd0;
        for (int i = 0; i < XLEN / w; i++) begin
            ai = (64'(a) >> (i*w)) & mask;
            bi = (64'(b) >> (i*w)) & mask;
            if (c) begin
                prod = 64'd0;
                for (int j = 0; j < w; j++) begin
                    if (bi[j]) prod = prod ^ (ai << j);
                end
            end else begin
                prod = ai * bi;
            end
            if (h)           lane = (prod >> w) & mask;
            else if (l || c) lane = prod & mask;
            else             lane = 64'd0;
            r = r | (lane[31:0] << (i*w));
        end
        return r;
    endfunction

    // Wait (bounded) for ready; also count cycles where result is nonzero without ready.
    task automatic wait_ready(output int lat, output int zviol);
        lat   = -1;
        zviol = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (ready === 1'b1) begin
                lat = k + 1;
                break;
            end
            if (result !== 32'd0) zviol++;
        end
    endtask

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] p,
                            input logic l, input logic h, input logic c);
        crs1  = a;
        crs2  = b;
        pw    = p;
        mul_l = l;
        mul_h = h;
        clmul = c;
    endtask

    // Full transaction from IDLE; inputs are scrambled after capture.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] p, input logic l, input logic h,
                          input logic c, input logic [31:0] exp);
        int lat;
        int zv;
        @(negedge clock);
        drive_op(a, b, p, l, h, c);
        valid = 1'b1;
        @(posedge clock); #1;
        drive_op($urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        wait_ready(lat, zv);
        check({name, "_lat"}, 64'(lat), 64'(LAT));
        check({name, "_res"}, 64'(result), 64'(exp));
        check({name, "_zero"}, 64'(zv), 64'd0);
        valid = 1'b0;
        @(posedge clock); #1;
        check({name, "_pulse"}, 64'(ready), 64'd0);
    endtask

    vec_t vecs[$];

    initial begin
        int lat;
        int zv;
        int bad;
        logic [31:0] ra, rb, e2;
        logic [4:0]  rp;
        logic        rl, rh, rc;

        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00001, 1'b1, 1'b0, 1'b0, 32'h00000001});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00001, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFE});
        vecs.push_back('{32'h02030405, 32'h03030303, 5'b00100, 1'b1, 1'b0, 1'b0, 32'h06090C0F});
        vecs.push_back('{32'hFF10FF02, 32'hFF10FF02, 5'b00100, 1'b0, 1'b1, 1'b0, 32'hFE01FE00});
        vecs.push_back('{32'h00000003, 32'h00000003, 5'b00001, 1'b0, 1'b0, 1'b1, 32'h00000005});
        vecs.push_back('{32'h80000000, 32'h00000002, 5'b00001, 1'b0, 1'b1, 1'b1, 32'h00000001});
        vecs.push_back('{32'h00000007, 32'h00000006, 5'b00000, 1'b1, 1'b0, 1'b0, 32'h0000002A});
        vecs.push_back('{32'h00030002, 32'h00050004, 5'b00110, 1'b1, 1'b0, 1'b0, 32'h000F0008});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 5'b10000, 1'b0, 1'b1, 1'b0, 32'hAAAAAAAA});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 5'b10000, 1'b1, 1'b0, 1'b0, 32'h55555555});
        vecs.push_back('{32'h12345678, 32'h9ABCDEF0, 5'b00001, 1'b0, 1'b0, 1'b0, 32'h00000000});
        vecs.push_back('{32'h00030003, 32'h00030003, 5'b00010, 1'b0, 1'b0, 1'b1, 32'h00050005});
        vecs.push_back('{32'h0000FFFF, 32'h0000FFFF, 5'b00010, 1'b1, 1'b1, 1'b0, 32'h0000FFFE});

        reset = 1'b1;
        valid = 1'b0;
        drive_op(32'd0, 32'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p,
                   vecs[i].l, vecs[i].h, vecs[i].c, vecs[i].exp);
        end

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            rp = 5'($urandom_range(0, 31));
            rl = 1'($urandom);
            rh = 1'($urandom);
            rc = 1'($urandom);
            run_op($sformatf("rand%0d", i), ra, rb, rp, rl, rh, rc, model(ra, rb, rp, rl, rh, rc));
        end

        // Abort: valid dropped in the 4th RUN cycle.
        @(negedge clock);
        drive_op(32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00001, 1'b1, 1'b0, 1'b0);
        valid = 1'b1;
        @(posedge clock); #1;
        repeat (3) @(posedge clock);
        #1;
        valid = 1'b0;
        bad = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clock); #1;
            if (ready !== 1'b0 || result !== 32'd0) bad++;
        end
        check("abort_quiet", 64'(bad), 64'd0);
        run_op("after_abort", 32'h02030405, 32'h03030303, 5'b00100, 1'b1, 1'b0, 1'b0, 32'h06090C0F);

        // Reset in the 5th RUN cycle, held with valid high for two edges.
        @(negedge clock);
        drive_op(32'h0000FFFF, 32'h0000FFFF, 5'b00001, 1'b1, 1'b0, 1'b0);
        valid = 1'b1;
        @(posedge clock); #1;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        valid = 1'b0;
        bad = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clock); #1;
            if (ready !== 1'b0 || result !== 32'd0) bad++;
        end
        check("rst_quiet", 64'(bad), 64'd0);
        run_op("after_rst", 32'h80000000, 32'h00000002, 5'b00001, 1'b0, 1'b1, 1'b1, 32'h00000001);

        // Back-to-back: valid held through DONE starts a second operation.
        @(negedge clock);
        drive_op(32'h00000003, 32'h00000003, 5'b00001, 1'b0, 1'b0, 1'b1);
        valid = 1'b1;
        @(posedge clock); #1;
        wait_ready(lat, zv);
        check("b2b1_lat", 64'(lat), 64'(LAT));
        check("b2b1_res", 64'(result), 64'h5);
        e2 = model(32'h12345678, 32'h0F0F0F0F, 5'b01000, 1'b0, 1'b1, 1'b0);
        drive_op(32'h12345678, 32'h0F0F0F0F, 5'b01000, 1'b0, 1'b1, 1'b0);
        @(posedge clock); #1;
        check("b2b_gap_ready", 64'(ready), 64'd0);
        check("b2b_gap_result", 64'(result), 64'd0);
        @(posedge clock); #1;
        wait_ready(lat, zv);
        check("b2b2_lat", 64'(lat), 64'(LAT));
        check("b2b2_res", 64'(result), 64'(e2));
        valid = 1'b0;
        @(posedge clock); #1;
        check("b2b2_pulse", 64'(ready), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/p_mul_mc.md
P_MUL_MC -- requirements
Module: p_mul_mc

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 Parameter BPC, default 4, multiplier bits retired per cycle; legal values 1, 2, 4, 8; must divide XLEN.
REQ-003 Derived localparam PWW = log2(XLEN) (5 for 32, 6 for 64), width of pw.
REQ-004 clock  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 valid  in  1  request present; held high until ready or abort.
REQ-007 ready  out  1  one-cycle pulse, result valid this cycle.
REQ-008 mul_l  in  1  low-half integer product select.
REQ-009 mul_h  in  1  high-half product select; overrides mul_l.
REQ-010 clmul  in  1  carry-less (GF(2)) product instead of integer product.
REQ-011 pw  in  PWW  one-hot lane width: pw[0]=XLEN, pw[1]=XLEN/2, ..., pw[PWW-1]=2.
REQ-012 crs1, crs2  in  XLEN  operands, lanes packed LSB first.
REQ-013 result  out  XLEN  packed lane results.

Function
REQ-014 States IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE: valid=1 captures crs1, crs2, pw, mul_l, mul_h, clmul; clears accumulator and counter; next state RUN.
REQ-016 RUN lasts exactly XLEN/BPC cycles; counter 0..XLEN/BPC-1; each cycle consumes next BPC multiplier bits of every lane (bits beyond lane width W contribute nothing).
REQ-017 RUN with valid=0 on any cycle: abort, next state IDLE, ready stays 0, result stays 0, no output produced.
REQ-018 RUN with last count: next state DONE.
REQ-019 DONE: ready=1 and result valid for exactly one cycle; next state IDLE unconditionally.
REQ-020 Latency: accept on edge N => ready=1 in cycle N+XLEN/BPC+1 (XLEN=32, BPC=4: 9 cycles).
REQ-021 New request accepted only in IDLE; valid still high in the cycle after DONE counts as a new request; requester drops valid the cycle after ready.
REQ-022 Inputs other than valid ignored after capture; changes during RUN have no effect.
REQ-023 Lane width W selected by pw; lane i = bits [i*W+W-1 : i*W] of each operand; XLEN/W lanes.
REQ-024 Per lane, unsigned: P = a_i*b_i (2W bits) if clmul=0; P = carry-less product, zero-extended to 2W bits, if clmul=1.
REQ-025 Lane result = P[2W-1:W] if mul_h=1, else P[W-1:0] if mul_l=1 or clmul=1; all zero if mul_l=mul_h=clmul=0.
REQ-026 No carry or partial product crosses a lane boundary.
REQ-027 pw zero or multi-hot: treated as lowest set bit; pw=0 treated as W=XLEN.
REQ-028 result = 0 whenever ready=0; registered output, no combinational input-to-output path.

Reset
REQ-029 reset=1 at a rising edge: state IDLE, ready=0, result=0, counter and accumulator cleared, regardless of state.
REQ-030 reset takes precedence over valid in the same cycle; no request accepted while reset=1.
REQ-031 In-flight operation interrupted by reset produces no ready pulse.

Verification (XLEN=32, BPC=4)
REQ-032 pw=00001, mul_l, crs1=crs2=0xFFFFFFFF -> ready in cycle 9 after accept, result=0x00000001; same with mul_h -> 0xFFFFFFFE.
REQ-033 pw=00100 (8-bit lanes), mul_l, crs1=0x02030405, crs2=0x03030303 -> result=0x06090C0F; with mul_h, crs1=crs2=0xFF10FF02 -> 0xFE01FE00.
REQ-034 pw=00001, clmul, crs1=crs2=0x00000003 -> 0x00000005; clmul+mul_h, crs1=0x80000000, crs2=0x00000002 -> 0x00000001.
REQ-035 Accept, drop valid in 4th RUN cycle -> ready never asserts, result stays 0, next request completes with correct value and latency.
REQ-036 Accept, assert reset in 5th RUN cycle -> ready=0, result=0 next cycle, state IDLE; new request after reset completes in 9 cycles.
REQ-037 Hold valid high through DONE -> second operation accepted the cycle after ready, second ready 9 cycles after that; ready high exactly one cycle each time.
